// File: rtl/clock_gated_exact_div_8by4_if.sv
// Request/result bundle for the sequential restoring divider.
// The master side issues operands and a start pulse; the slave side reports status and results.
interface clock_gated_exact_div_8by4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic          dz;
    logic [DW-1:0] Q;
    logic [VW-1:0] R;

    modport master (
        output start, dividend, divisor,
        input  busy, done, dz, Q, R
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, dz, Q, R
    );
endinterface

// File: rtl/clock_gated_exact_div_8by4.sv
// Sequential restoring divider: one quotient bit per enabled falling edge, MSB first.
// Inverse of the 4-bit exact multiplier; en freezes every register in the block.
module clock_gated_exact_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    clock_gated_exact_div_8by4_if.slave bus
);

    localparam int CW = $clog2(DW);
    localparam int RW = VW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_reg;
    logic [VW-1:0] dvs_reg;
    logic [RW-1:0] rem;
    logic [DW-1:0] quo;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] r_reg;
    logic          dz_reg;

    logic [RW-1:0] shifted;
    logic [RW-1:0] diff;
    logic          qbit;
    logic          last_step;
    logic          accept;
    logic          zero_div;

    // One restoring step: shift in the next dividend bit, then trial-subtract the divisor
    always_comb begin
        shifted   = RW'({rem, dvd_reg[DW-1]});
        qbit      = (shifted >= {1'b0, dvs_reg});
        diff      = qbit ? (shifted - {1'b0, dvs_reg}) : shifted;
        last_step = (cnt == CW'(DW - 1));
        accept    = bus.start && ((state == IDLE) || (state == DONE));
        zero_div  = (dvs_reg == '0);
    end

    // Next-state logic; a zero divisor skips the steps after a single RUN edge so done lands one edge after accept
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (zero_div || last_step) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, advanced only on enabled falling edges
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Operand capture, iteration datapath and atomic result update at completion
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dvd_reg <= '0;
            dvs_reg <= '0;
            rem     <= '0;
            quo     <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dz_reg  <= 1'b0;
        end else if (en) begin
            if (accept) begin
                dvd_reg <= bus.dividend;
                dvs_reg <= bus.divisor;
                rem     <= '0;
                quo     <= '0;
                cnt     <= '0;
            end else if (state == RUN) begin
                if (zero_div) begin
                    q_reg  <= '1;
                    r_reg  <= dvd_reg[VW-1:0];
                    dz_reg <= 1'b1;
                end else begin
                    rem     <= diff;
                    quo     <= {quo[DW-2:0], qbit};
                    dvd_reg <= {dvd_reg[DW-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                    if (last_step) begin
                        q_reg  <= {quo[DW-2:0], qbit};
                        r_reg  <= diff[VW-1:0];
                        dz_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.dz   = dz_reg;
    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;

endmodule

// File: tb/tb_clock_gated_exact_div_8by4.sv
// Testbench for the restoring divider: directed cases plus a full operand sweep
// checked against an arithmetic reference (a/b, a%b, divide-by-zero rules).
module tb_clock_gated_exact_div_8by4;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk;
    logic rst_n;
    logic en;

    int n_checks;
    int n_errors;

    logic [DW-1:0] exp_q;
    logic [VW-1:0] exp_r;
    logic          exp_dz;

    clock_gated_exact_div_8by4_if #(.DW(DW), .VW(VW)) bus ();

    clock_gated_exact_div_8by4 #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic [DW-1:0] a,
                                 input logic [VW-1:0] b, input logic e);
        bus.start    = st;
        bus.dividend = a;
        bus.divisor  = b;
        en           = e;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one division starting at a posedge (outputs idle or done).
    // en_mode: 0 = always enabled, 1 = random enable, 2 = three disabled cycles mid-run.
    task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b, input int en_mode);
        int            steps;
        int            iters;
        int            needed;
        logic          en_v;
        logic [DW-1:0] mq;
        logic [VW-1:0] mr;
        logic          mdz;

        if (b == 0) begin
            mq     = '1;
            mr     = a[VW-1:0];
            mdz    = 1'b1;
            needed = 1;
        end else begin
            mq     = a / b;
            mr     = VW'(a % b);
            mdz    = 1'b0;
            needed = DW;
        end

        applyStimulus(1'b1, a, b, 1'b1);
        @(posedge clk);
        checkOutput("busy_after_accept", bus.busy, 1);
        checkOutput("done_after_accept", bus.done, 0);
        checkOutput("q_hold_accept", bus.Q, exp_q);

        steps = 0;
        iters = 0;
        while (steps < needed && iters < 64) begin
            if (en_mode == 1)
                en_v = ($urandom_range(0, 3) != 0);
            else if (en_mode == 2)
                en_v = !(iters >= 3 && iters < 6);
            else
                en_v = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), VW'($urandom), en_v);
            @(posedge clk);
            iters++;
            if (en_v) steps++;
            if (steps < needed) begin
                checkOutput("busy_run", bus.busy, 1);
                checkOutput("done_run", bus.done, 0);
                checkOutput("q_hold_run", bus.Q, exp_q);
                checkOutput("r_hold_run", bus.R, exp_r);
            end
        end

        if (steps < needed) begin
            checkOutput("timeout_steps", steps, needed);
        end else begin
            exp_q  = mq;
            exp_r  = mr;
            exp_dz = mdz;
            checkOutput("done_final", bus.done, 1);
            checkOutput("busy_final", bus.busy, 0);
            checkOutput("q_final", bus.Q, exp_q);
            checkOutput("r_final", bus.R, exp_r);
            checkOutput("dz_final", bus.dz, exp_dz);
        end
        if (en_mode == 2) checkOutput("latency_stretched", iters, DW + 3);

        bus.start = 1'b0;
        en        = 1'b1;
    endtask

    initial begin
        int p;
        n_checks = 0;
        n_errors = 0;
        exp_q    = '0;
        exp_r    = '0;
        exp_dz   = 1'b0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);

        @(posedge clk);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_dz", bus.dz, 0);
        checkOutput("rst_q", bus.Q, 0);
        checkOutput("rst_r", bus.R, 0);
        rst_n = 1'b1;
        @(posedge clk);
        checkOutput("idle_busy", bus.busy, 0);

        $display("[TB] T1: 143/11");
        do_div(8'd143, 4'd11, 0);
        @(posedge clk);
        checkOutput("t1_idle_done", bus.done, 0);
        checkOutput("t1_idle_busy", bus.busy, 0);
        checkOutput("t1_q_held", bus.Q, 13);

        $display("[TB] T2: 200/7 then 255/15 back-to-back");
        do_div(8'd200, 4'd7, 0);
        do_div(8'd255, 4'd15, 0);

        $display("[TB] T3: 77/0");
        do_div(8'd77, 4'd0, 0);
        checkOutput("t3_q", bus.Q, 255);
        checkOutput("t3_r", bus.R, 13);

        $display("[TB] T4: 200/7 with enable gaps");
        do_div(8'd200, 4'd7, 2);
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(posedge clk);
        checkOutput("t4_done_frozen", bus.done, 1);
        en = 1'b1;
        @(posedge clk);
        checkOutput("t4_done_cleared", bus.done, 0);
        checkOutput("t4_busy_idle", bus.busy, 0);

        $display("[TB] T5: async reset mid-run");
        applyStimulus(1'b1, 8'd99, 4'd5, 1'b1);
        @(posedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", bus.busy, 0);
        checkOutput("t5_done", bus.done, 0);
        checkOutput("t5_q", bus.Q, 0);
        checkOutput("t5_r", bus.R, 0);
        checkOutput("t5_dz", bus.dz, 0);
        exp_q  = '0;
        exp_r  = '0;
        exp_dz = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        do_div(8'd0, 4'd5, 0);

        $display("[TB] T6: full operand sweep");
        for (int idx = 0; idx < 4096; idx++) begin
            p = (idx * 2897 + 1234) % 4096;
            do_div(DW'(p >> 4), VW'(p), ($urandom_range(0, 7) == 0) ? 1 : 0);
            if ($urandom_range(0, 15) == 0) begin
                @(posedge clk);
                checkOutput("sweep_idle_busy", bus.busy, 0);
                checkOutput("sweep_idle_done", bus.done, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
